// File: rtl/lcd_rx_pkg.sv
// rtl/lcd_rx_pkg.sv - opcodes, FSM states and pixel type for the 8080-style LCD bus receiver
package lcd_rx_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET_P,
        ST_RASET_P,
        ST_RAMWR_HI,
        ST_RAMWR_LO,
        ST_IGNORE
    } rx_state_e;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] rgb565;
    } pixel_t;

    // Parameterless commands park in IDLE so stray data bytes are dropped.
    function automatic rx_state_e cmd_state(input logic [7:0] op);
        case (op)
            CMD_CASET:   return ST_CASET_P;
            CMD_RASET:   return ST_RASET_P;
            CMD_RAMWR:   return ST_RAMWR_HI;
            CMD_SWRESET,
            CMD_DISPON,
            CMD_DISPOFF: return ST_IDLE;
            default:     return ST_IGNORE;
        endcase
    endfunction

endpackage

// File: rtl/lcd_wr_strobe.sv
// rtl/lcd_wr_strobe.sv - rising-edge detect on wr and byte capture for the LCD bus receiver
module lcd_wr_strobe (
    input  logic       clk,
    input  logic       nrst,
    input  logic       wr,
    input  logic       dcx,
    input  logic [7:0] d,
    output logic       byte_valid,
    output logic       is_cmd,
    output logic [7:0] rx_byte
);

    logic wr_q;

    // wr_q resets high so an idle-high bus leaving reset is not seen as an edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_q <= 1'b1;
        end else begin
            wr_q <= wr;
        end
    end

    assign byte_valid = wr & ~wr_q;
    assign is_cmd     = ~dcx;
    assign rx_byte    = d;

endmodule

// File: rtl/lcd_bus_receiver.sv
// rtl/lcd_bus_receiver.sv - LCD write-bus command decoder producing RGB565 pixel writes; LCD_RX_BOUNDS_CHECK_EN enables out-of-bounds suppression
module lcd_bus_receiver
    import lcd_rx_pkg::*;
#(
    parameter int H_RES   = 240,
    parameter int V_RES   = 320,
    parameter int COORD_W = 9
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               sync,
    input  logic               wr,
    input  logic               dcx,
    input  logic [7:0]         D,
    output logic               pixel_valid,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic [15:0]        pixel_data,
    output logic               frame_start,
    output logic               disp_on,
    output logic [7:0]         last_cmd,
    output logic               oob_err
);

    localparam logic [COORD_W-1:0] FULL_EC = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] FULL_ER = COORD_W'(V_RES - 1);

    logic               byte_valid;
    logic               is_cmd;
    logic [7:0]         rx_byte;
    logic               accept;
    rx_state_e          state;
    logic [1:0]         pidx;
    logic [7:0]         p0, p1, p2, hi_q;
    logic [COORD_W-1:0] sc, ec, sr, er, cur_x, cur_y;
    logic [COORD_W-1:0] eff_ec, eff_er, start_val, end_val;
    logic               oob_hit;
    logic               oob_err_q;

    lcd_wr_strobe u_strobe (
        .clk        (clk),
        .nrst       (nrst),
        .wr         (wr),
        .dcx        (dcx),
        .d          (D),
        .byte_valid (byte_valid),
        .is_cmd     (is_cmd),
        .rx_byte    (rx_byte)
    );

    assign accept    = byte_valid & ~sync;
    // An inverted window collapses to its start coordinate.
    assign eff_ec    = (sc > ec) ? sc : ec;
    assign eff_er    = (sr > er) ? sr : er;
    assign start_val = COORD_W'({p0, p1});
    assign end_val   = COORD_W'({p2, rx_byte});

`ifdef LCD_RX_BOUNDS_CHECK_EN
    assign oob_hit = (32'(cur_x) >= 32'(H_RES)) || (32'(cur_y) >= 32'(V_RES));
    assign oob_err = oob_err_q;
`else
    assign oob_hit = 1'b0;
    assign oob_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= ST_IDLE;
            pidx        <= 2'd0;
            p0          <= 8'h00;
            p1          <= 8'h00;
            p2          <= 8'h00;
            hi_q        <= 8'h00;
            sc          <= '0;
            ec          <= FULL_EC;
            sr          <= '0;
            er          <= FULL_ER;
            cur_x       <= '0;
            cur_y       <= '0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_data  <= 16'h0000;
            frame_start <= 1'b0;
            disp_on     <= 1'b0;
            last_cmd    <= 8'h00;
            oob_err_q   <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            if (sync) begin
                state <= ST_IDLE;
            end else if (accept && is_cmd) begin
                last_cmd <= rx_byte;
                pidx     <= 2'd0;
                state    <= cmd_state(rx_byte);
                case (rx_byte)
                    CMD_DISPON:  disp_on <= 1'b1;
                    CMD_DISPOFF: disp_on <= 1'b0;
                    CMD_SWRESET: begin
                        disp_on   <= 1'b0;
                        sc        <= '0;
                        ec        <= FULL_EC;
                        sr        <= '0;
                        er        <= FULL_ER;
                        oob_err_q <= 1'b0;
                    end
                    CMD_RAMWR: begin
                        cur_x       <= sc;
                        cur_y       <= sr;
                        frame_start <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (accept) begin
                case (state)
                    ST_CASET_P, ST_RASET_P: begin
                        pidx <= pidx + 2'd1;
                        case (pidx)
                            2'd0: p0 <= rx_byte;
                            2'd1: p1 <= rx_byte;
                            2'd2: p2 <= rx_byte;
                            default: begin
                                // Fourth parameter commits; anything further is ignored.
                                if (state == ST_CASET_P) begin
                                    sc <= start_val;
                                    ec <= end_val;
                                end else begin
                                    sr <= start_val;
                                    er <= end_val;
                                end
                                state <= ST_IGNORE;
                            end
                        endcase
                    end
                    ST_RAMWR_HI: begin
                        hi_q  <= rx_byte;
                        state <= ST_RAMWR_LO;
                    end
                    ST_RAMWR_LO: begin
                        state <= ST_RAMWR_HI;
                        if (oob_hit) begin
                            oob_err_q <= 1'b1;
                        end else begin
                            pixel_valid <= 1'b1;
                            pixel_x     <= cur_x;
                            pixel_y     <= cur_y;
                            pixel_data  <= {hi_q, rx_byte};
                        end
                        if (cur_x == eff_ec) begin
                            cur_x <= sc;
                            cur_y <= (cur_y == eff_er) ? sr : cur_y + 1'b1;
                        end else begin
                            cur_x <= cur_x + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb/tb_lcd_bus_receiver.sv - scoreboard testbench for lcd_bus_receiver
module tb_lcd_bus_receiver;
    import lcd_rx_pkg::*;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       sync = 1'b0;
    logic       wr = 1'b1;
    logic       dcx = 1'b1;
    logic [7:0] D = 8'h00;
    logic       pixel_valid;
    logic [8:0] pixel_x;
    logic [8:0] pixel_y;
    logic [15:0] pixel_data;
    logic       frame_start;
    logic       disp_on;
    logic [7:0] last_cmd;
    logic       oob_err;

    int     n_vec = 0;
    int     n_err = 0;
    int     fs_seen = 0;
    int     fs_exp = 0;
    pixel_t exp_q[$];
    pixel_t e;

    lcd_bus_receiver #(.H_RES(240), .V_RES(320), .COORD_W(9)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .sync        (sync),
        .wr          (wr),
        .dcx         (dcx),
        .D           (D),
        .pixel_valid (pixel_valid),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_data  (pixel_data),
        .frame_start (frame_start),
        .disp_on     (disp_on),
        .last_cmd    (last_cmd),
        .oob_err     (oob_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (nrst) begin
            if (frame_start) fs_seen++;
            if (pixel_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pixel: got x=%0d y=%0d data=%h expected none",
                             pixel_x, pixel_y, pixel_data);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", {16'(pixel_x), 16'(pixel_y), pixel_data}, e);
                end
            end
        end
    end

    task automatic send(input logic c_dcx, input logic [7:0] b);
        dcx = c_dcx;
        D   = b;
        wr  = 1'b0;
        @(posedge clk); #1;
        wr  = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic cmd(input logic [7:0] b);
        send(1'b0, b);
        if (b == CMD_RAMWR) fs_exp++;
    endtask

    task automatic dat(input logic [7:0] b);
        send(1'b1, b);
    endtask

    task automatic win(input logic [7:0] op, input logic [15:0] s, input logic [15:0] en);
        cmd(op);
        dat(s[15:8]); dat(s[7:0]); dat(en[15:8]); dat(en[7:0]);
    endtask

    task automatic px(input logic [7:0] hi, input logic [7:0] lo, input int ex, input int ey,
                      input bit emit);
        if (emit) exp_q.push_back('{x: 16'(ex), y: 16'(ey), rgb565: {hi, lo}});
        dat(hi);
        dat(lo);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        idle(2);
        check("rst_pixel_valid", 48'(pixel_valid), 48'h0);
        check("rst_frame_start", 48'(frame_start), 48'h0);
        check("rst_pixel_xyd", {16'(pixel_x), 16'(pixel_y), pixel_data}, 48'h0);
        check("rst_disp_on", 48'(disp_on), 48'h0);
        check("rst_last_cmd", 48'(last_cmd), 48'h0);
        check("rst_oob_err", 48'(oob_err), 48'h0);
        nrst = 1'b1;
        idle(3);
        check("no_false_edge", 48'(fs_seen), 48'h0);

        // basic 2x2 window at (10..11, 20..21)
        win(CMD_CASET, 16'd10, 16'd11);
        win(CMD_RASET, 16'd20, 16'd21);
        cmd(CMD_RAMWR);
        px(8'hAA, 8'hBB, 10, 20, 1'b1);
        px(8'h12, 8'h34, 11, 20, 1'b1);
        px(8'h56, 8'h78, 10, 21, 1'b1);
        px(8'h9A, 8'hBC, 11, 21, 1'b1);
        check("last_cmd_ramwr", 48'(last_cmd), 48'h2C);

        // frame wrap on a 2x2 window
        win(CMD_CASET, 16'd5, 16'd6);
        win(CMD_RASET, 16'd7, 16'd8);
        cmd(CMD_RAMWR);
        px(8'h01, 8'h11, 5, 7, 1'b1);
        px(8'h02, 8'h22, 6, 7, 1'b1);
        px(8'h03, 8'h33, 5, 8, 1'b1);
        px(8'h04, 8'h44, 6, 8, 1'b1);
        px(8'h05, 8'h55, 5, 7, 1'b1);

        // truncated CASET keeps the old window
        cmd(CMD_CASET); dat(8'h00); dat(8'h30);
        cmd(CMD_RAMWR);
        px(8'hC0, 8'hDE, 5, 7, 1'b1);

        // sync drops a pending high byte and a strobe coincident with it
        cmd(CMD_RAMWR);
        dat(8'h11);
        dcx = 1'b1; D = 8'h55; wr = 1'b0;
        @(posedge clk); #1;
        wr = 1'b1; sync = 1'b1;
        @(posedge clk); #1;
        sync = 1'b0;
        dat(8'h22);
        cmd(CMD_RAMWR);
        px(8'h33, 8'h44, 5, 7, 1'b1);

        // display on/off and software reset
        check("disp_on_before", 48'(disp_on), 48'h0);
        cmd(CMD_DISPON);
        check("dispon", 48'(disp_on), 48'h1);
        cmd(CMD_DISPOFF);
        check("dispoff", 48'(disp_on), 48'h0);
        cmd(CMD_DISPON);
        cmd(CMD_SWRESET);
        check("swreset_disp_on", 48'(disp_on), 48'h0);
        check("swreset_last_cmd", 48'(last_cmd), 48'h01);
        cmd(CMD_RAMWR);
        px(8'hDE, 8'hAD, 0, 0, 1'b1);
        px(8'hBE, 8'hEF, 1, 0, 1'b1);

        // unknown opcode swallows its data
        cmd(8'hB1);
        dat(8'h10); dat(8'h20); dat(8'h30);
        check("unknown_last_cmd", 48'(last_cmd), 48'hB1);
        check("unknown_disp_on", 48'(disp_on), 48'h0);

        // inverted column window: x stays at SC
        win(CMD_CASET, 16'd9, 16'd3);
        win(CMD_RASET, 16'd2, 16'd3);
        cmd(CMD_RAMWR);
        px(8'h01, 8'h02, 9, 2, 1'b1);
        px(8'h03, 8'h04, 9, 3, 1'b1);
        px(8'h05, 8'h06, 9, 2, 1'b1);

        // window straddling the right edge of the panel
        win(CMD_CASET, 16'd238, 16'd241);
        win(CMD_RASET, 16'd0, 16'd0);
        cmd(CMD_RAMWR);
        px(8'hA1, 8'hB1, 238, 0, 1'b1);
        px(8'hA2, 8'hB2, 239, 0, 1'b1);
`ifdef LCD_RX_BOUNDS_CHECK_EN
        px(8'hA3, 8'hB3, 240, 0, 1'b0);
        px(8'hA4, 8'hB4, 241, 0, 1'b0);
        idle(3);
        check("oob_err_set", 48'(oob_err), 48'h1);
        check("hold_after_oob", {16'(pixel_x), 16'(pixel_y), pixel_data}, {16'd239, 16'd0, 16'hA2B2});
`else
        px(8'hA3, 8'hB3, 240, 0, 1'b1);
        px(8'hA4, 8'hB4, 241, 0, 1'b1);
        idle(3);
        check("oob_err_tied", 48'(oob_err), 48'h0);
        check("hold_after_edge", {16'(pixel_x), 16'(pixel_y), pixel_data}, {16'd241, 16'd0, 16'hA4B4});
`endif

        // reset in the middle of a pixel
        cmd(CMD_RAMWR);
        dat(8'h77);
        nrst = 1'b0;
        #1;
        check("midrst_pixel_valid", 48'(pixel_valid), 48'h0);
        check("midrst_frame_start", 48'(frame_start), 48'h0);
        check("midrst_last_cmd", 48'(last_cmd), 48'h0);
        check("midrst_pixel_xyd", {16'(pixel_x), 16'(pixel_y), pixel_data}, 48'h0);
        check("midrst_oob_err", 48'(oob_err), 48'h0);
        idle(2);
        check("midrst_hold_valid", 48'(pixel_valid | frame_start), 48'h0);
        nrst = 1'b1;
        idle(1);
        dat(8'h88);
        idle(4);

        check("queue_drained", 48'(exp_q.size()), 48'h0);
        check("frame_start_count", 48'(fs_seen), 48'(fs_exp));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
